// File: rtl/sequence_checker.sv
// sequence_checker: lock/error monitor for a load/wrap counter stream; SEQ_CHK_STICKY_EN adds err_clr/err_sticky
module sequence_checker #(
    parameter int WIDTH     = 4,
    parameter int LOAD_VAL  = 4,
    parameter int WRAP_VAL  = 7,
    parameter int LOCK_CNT  = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic                 a_in,
    input  logic [WIDTH-1:0]     q_in,
`ifdef SEQ_CHK_STICKY_EN
    input  logic                 err_clr,
    output logic                 err_sticky,
`endif
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] LOAD_V = WIDTH'(LOAD_VAL);
    localparam logic [WIDTH-1:0] WRAP_V = WIDTH'(WRAP_VAL);

    typedef enum logic [1:0] {UNSYNC, SYNC, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ref_q, exp_val;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             match, err_d;

    function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] inc;
        inc = r + WIDTH'(1);
        return (inc == WRAP_V) ? '0 : inc;
    endfunction

    assign exp_val = a_in ? LOAD_V : succ(ref_q);
    assign match   = (q_in == exp_val);
    assign locked  = (state_q == LOCKED);

    // next state, match run length and error detection for the current sample
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (valid) begin
            case (state_q)
                UNSYNC: begin
                    state_d = SYNC;
                    cnt_d   = '0;
                end
                SYNC: begin
                    state_d = (match && cnt_q == CW'(LOCK_CNT - 1)) ? LOCKED : SYNC;
                    cnt_d   = (match && cnt_q != CW'(LOCK_CNT - 1)) ? cnt_q + CW'(1) : '0;
                end
                default: begin
                    err_d   = !match;
                    state_d = match ? LOCKED : SYNC;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // state, reference value and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= UNSYNC;
            cnt_q     <= '0;
            ref_q     <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            expected  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_pulse <= err_d;
            err_count <= (err_d && err_count != '1) ? err_count + ERR_CNT_W'(1) : err_count;
            ref_q     <= valid ? q_in : ref_q;
            expected  <= valid ? succ(q_in) : expected;
        end
    end

`ifdef SEQ_CHK_STICKY_EN
    // sticky flag follows err_pulse; a pending error beats a clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_sticky <= 1'b0;
        else
            err_sticky <= err_pulse ? 1'b1 : (err_clr ? 1'b0 : err_sticky);
    end
`endif
endmodule

// File: tb/tb_sequence_checker.sv
// tb_sequence_checker: directed and random stimulus against a behavioural model of sequence_checker
module tb_sequence_checker;
    localparam int LOAD = 4;
    localparam int WRAP = 7;
    localparam int LOCK = 3;
    localparam int EMAX = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid = 1'b0;
    logic       a_in = 1'b0;
    logic [3:0] q_in = '0;
    logic       err_clr = 1'b0;
    logic       err_sticky;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [3:0] expected;

    int n_vec = 0;
    int n_err = 0;

    int m_ref = 0, m_exp = 0, m_cnt = 0, m_run = 0;
    bit m_sync = 0, m_lock = 0, m_pulse = 0, m_sticky = 0;

    sequence_checker dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid(valid),
        .a_in(a_in),
        .q_in(q_in),
`ifdef SEQ_CHK_STICKY_EN
        .err_clr(err_clr),
        .err_sticky(err_sticky),
`endif
        .locked(locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .expected(expected)
    );

`ifndef SEQ_CHK_STICKY_EN
    assign err_sticky = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic int nxt(input int r);
        int i;
        i = (r + 1) % 16;
        return (i == WRAP) ? 0 : i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_ref = 0; m_exp = 0; m_cnt = 0; m_run = 0;
        m_sync = 0; m_lock = 0; m_pulse = 0; m_sticky = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"}, 32'(locked), 32'(m_lock));
        chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
        chk({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
        chk({tag, ".expected"}, 32'(expected), 32'(m_exp));
`ifdef SEQ_CHK_STICKY_EN
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic a, input logic [3:0] q, input logic c);
        int e;
        @(negedge clk);
        valid = v; a_in = a; q_in = q; err_clr = c;
        @(posedge clk);
        m_sticky = m_pulse ? 1'b1 : (c ? 1'b0 : m_sticky);
        m_pulse = 0;
        if (v) begin
            e = a ? LOAD : nxt(m_ref);
            if (!m_sync) begin
                m_sync = 1; m_run = 0;
            end else if (!m_lock) begin
                if (int'(q) == e) begin
                    m_run++;
                    if (m_run == LOCK) begin m_lock = 1; m_run = 0; end
                end else m_run = 0;
            end else if (int'(q) != e) begin
                m_pulse = 1;
                if (m_cnt < EMAX) m_cnt++;
                m_lock = 0; m_run = 0;
            end
            m_ref = int'(q);
            m_exp = nxt(int'(q));
        end
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic relock();
        for (int i = 0; i < LOCK; i++) step("relock", 1'b1, 1'b0, 4'(nxt(m_ref)), 1'b0);
    endtask

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        #1 check_all("reset");
        @(negedge clk) rst_n = 1'b1;

        // capture 4, then 5,6,0 lock; expected becomes 1
        step("t1_cap", 1'b1, 1'b0, 4'd4, 1'b0);
        step("t1_s5", 1'b1, 1'b0, 4'd5, 1'b0);
        step("t1_s6", 1'b1, 1'b0, 4'd6, 1'b0);
        step("t1_s0", 1'b1, 1'b0, 4'd0, 1'b0);
        chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_expected", 32'(expected), 32'd1);

        // load request while locked is a match
        step("t2_s1", 1'b1, 1'b0, 4'd1, 1'b0);
        step("t2_s2", 1'b1, 1'b0, 4'd2, 1'b0);
        step("t2_s3", 1'b1, 1'b0, 4'd3, 1'b0);
        step("t2_load", 1'b1, 1'b1, 4'd4, 1'b0);
        chk("t2_locked", 32'(locked), 32'd1);

        // WRAP_VAL value while locked is an error; relock from ref 7 (8,9,10)
        step("t3_s5", 1'b1, 1'b0, 4'd5, 1'b0);
        step("t3_wrap", 1'b1, 1'b0, 4'd7, 1'b0);
        chk("t3_pulse", 32'(err_pulse), 32'd1);
        chk("t3_count", 32'(err_count), 32'd1);
        step("t3_s8", 1'b1, 1'b0, 4'd8, 1'b0);
        chk("t3_pulse_drop", 32'(err_pulse), 32'd0);
        step("t3_s9", 1'b1, 1'b0, 4'd9, 1'b0);
        step("t3_s10", 1'b1, 1'b0, 4'd10, 1'b0);
        chk("t3_relocked", 32'(locked), 32'd1);
        step("t3_idle", 1'b0, 1'b0, 4'd3, 1'b0);

        // 300 errors each after a relock: counter saturates
        for (int i = 0; i < 300; i++) begin
            step("t4_err", 1'b1, 1'b0, 4'd7, 1'b0);
            relock();
        end
        chk("t4_sat", 32'(err_count), 32'd255);

        // five errors, then async reset while locked
        async_reset("t5_pre_rst");
        step("t5_cap", 1'b1, 1'b0, 4'd2, 1'b0);
        relock();
        for (int i = 0; i < 5; i++) begin
            step("t5_err", 1'b1, 1'b0, 4'd7, 1'b0);
            relock();
        end
        chk("t5_count5", 32'(err_count), 32'd5);
        async_reset("t5_async");
        step("t5_capture_only", 1'b1, 1'b0, 4'd9, 1'b0);
        step("t5_first_match", 1'b1, 1'b0, 4'd10, 1'b0);

`ifdef SEQ_CHK_STICKY_EN
        relock();
        step("t6_err", 1'b1, 1'b0, 4'd7, 1'b0);
        step("t6_set_vs_clr", 1'b0, 1'b0, 4'd0, 1'b1);
        chk("t6_sticky_set", 32'(err_sticky), 32'd1);
        step("t6_clr", 1'b0, 1'b0, 4'd0, 1'b1);
        chk("t6_sticky_clr", 32'(err_sticky), 32'd0);
`endif

        // random stream, mostly well-formed so the checker locks and errs
        for (int i = 0; i < 600; i++) begin
            logic v, a, c;
            logic [3:0] q;
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 5) == 0);
            q = ($urandom_range(0, 4) != 0) ? 4'(a ? LOAD : nxt(m_ref)) : 4'($urandom_range(0, 15));
            step("rand", v, a, q, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
